// File: rtl/alu_op_sequencer.sv
// Command front-end and checker for a registered 4-bit ALU stage: issues one
// operation, samples the result after LAT edges and compares it with a golden model.
module alu_op_sequencer #(
   parameter int unsigned LAT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic [1:0] cmd_s,
   input  logic       cmd_cin,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [1:0] alu_s,
   output logic       alu_cin,
   input  logic [3:0] alu_d,
   input  logic       alu_cout,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_d,
   output logic       rsp_cout,
   output logic       rsp_err,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [2:0] LAT_C = 3'(LAT);

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       cmd_ready_q, cmd_ready_d;
   logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0] alu_s_q, alu_s_d;
   logic       alu_cin_q, alu_cin_d;
   logic [4:0] exp_q, exp_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [3:0] rsp_d_q, rsp_d_d;
   logic       rsp_cout_q, rsp_cout_d;
   logic       rsp_err_q, rsp_err_d;
   logic [7:0] err_count_q, err_count_d;
   logic       accept;
   logic       mismatch;

   // Mirrors the ALU B-path mux: B, ~B, 0 or all-ones, then A + M + Cin.
   function automatic logic [4:0] golden(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s, input logic cin);
      logic [3:0] m;
      case (s)
         2'b00:   m = b;
         2'b01:   m = ~b;
         2'b10:   m = 4'h0;
         default: m = 4'hF;
      endcase
      return {1'b0, a} + {1'b0, m} + {4'b0, cin};
   endfunction

   assign accept   = (state_q == IDLE) && cmd_ready_q && cmd_valid;
   assign mismatch = ({alu_cout, alu_d} != exp_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_s_d     = alu_s_q;
      alu_cin_d   = alu_cin_q;
      exp_d       = exp_q;
      rsp_d_d     = rsp_d_q;
      rsp_cout_d  = rsp_cout_q;
      rsp_err_d   = rsp_err_q;
      err_count_d = err_count_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               alu_a_d   = cmd_a;
               alu_b_d   = cmd_b;
               alu_s_d   = cmd_s;
               alu_cin_d = cmd_cin;
               exp_d     = golden(cmd_a, cmd_b, cmd_s, cmd_cin);
               cnt_d     = LAT_C;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               rsp_d_d    = alu_d;
               rsp_cout_d = alu_cout;
               rsp_err_d  = mismatch;
               if (mismatch && (err_count_q != 8'hFF))
                  err_count_d = err_count_q + 8'd1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            if (rsp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Registered handshakes follow the state being entered.
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         cmd_ready_q <= 1'b0;
         alu_a_q     <= 4'h0;
         alu_b_q     <= 4'h0;
         alu_s_q     <= 2'b00;
         alu_cin_q   <= 1'b0;
         exp_q       <= 5'h00;
         rsp_valid_q <= 1'b0;
         rsp_d_q     <= 4'h0;
         rsp_cout_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         err_count_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_s_q     <= alu_s_d;
         alu_cin_q   <= alu_cin_d;
         exp_q       <= exp_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_d_q     <= rsp_d_d;
         rsp_cout_q  <= rsp_cout_d;
         rsp_err_q   <= rsp_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_s     = alu_s_q;
   assign alu_cin   = alu_cin_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_d     = rsp_d_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_err   = rsp_err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer driving a behavioral two-register ALU.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready;
   logic [3:0] cmd_a, cmd_b;
   logic [1:0] cmd_s;
   logic       cmd_cin;
   logic [3:0] alu_a, alu_b;
   logic [1:0] alu_s;
   logic       alu_cin;
   logic [3:0] alu_d;
   logic       alu_cout;
   logic       rsp_valid, rsp_ready;
   logic [3:0] rsp_d;
   logic       rsp_cout, rsp_err;
   logic [7:0] err_count;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.LAT(2)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .cmd_cin(cmd_cin),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
      .alu_d(alu_d), .alu_cout(alu_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_d(rsp_d), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
      .err_count(err_count)
   );

   // Behavioral ALU: input register then output register (two-edge latency).
   logic [3:0] ia = 4'h0, ib = 4'h0;
   logic [1:0] is = 2'b00;
   logic       ic = 1'b0;
   logic [4:0] res_q = 5'h00;
   logic       stuck0 = 1'b0;

   function automatic logic [4:0] alu_beh(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] s, input logic c);
      int r;
      case (s)
         2'b00:   r = int'(a) + int'(b) + int'(c);
         2'b01:   r = int'(a) + (15 - int'(b)) + int'(c);
         2'b10:   r = int'(a) + int'(c);
         default: r = int'(a) + 15 + int'(c);
      endcase
      return 5'(r);
   endfunction

   always @(posedge clk) begin
      ia    <= alu_a;
      ib    <= alu_b;
      is    <= alu_s;
      ic    <= alu_cin;
      res_q <= alu_beh(ia, ib, is, ic);
   end

   assign alu_d    = res_q[3:0] & {3'b111, ~stuck0};
   assign alu_cout = res_q[4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one command with rsp_ready high; check latency, response and release.
   task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] s, input logic c,
                        input logic [3:0] ed, input logic ec, input logic ee);
      int n;
      @(negedge clk);
      cmd_a = a; cmd_b = b; cmd_s = s; cmd_cin = c;
      cmd_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, "_busy"}, 32'(cmd_ready), 32'd0);
      chk({tag, "_alu_a"}, 32'(alu_a), 32'(a));
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, 32'(n), 32'd3);
      chk({tag, "_d"}, 32'(rsp_d), 32'(ed));
      chk({tag, "_cout"}, 32'(rsp_cout), 32'(ec));
      chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int n;
      int seen;
      reset = 1'b0;
      cmd_valid = 1'b0; cmd_a = 4'h0; cmd_b = 4'h0; cmd_s = 2'b00; cmd_cin = 1'b0;
      rsp_ready = 1'b0;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu", {19'd0, alu_a, alu_b, alu_s, alu_cin}, 32'd0);
      chk("rst_rsp", {26'd0, rsp_d, rsp_cout, rsp_err}, 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      reset = 1'b1;
      #1;
      chk("rel_ready_pre_edge", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rel_ready", 32'(cmd_ready), 32'd1);
      chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);

      // Arithmetic on a healthy ALU
      do_op("add", 4'h7, 4'h9, 2'b00, 1'b1, 4'h1, 1'b1, 1'b0);
      do_op("sub", 4'h5, 4'h3, 2'b01, 1'b1, 4'h2, 1'b1, 1'b0);
      do_op("dec", 4'h0, 4'h0, 2'b11, 1'b0, 4'hF, 1'b0, 1'b0);
      do_op("inc", 4'hF, 4'h0, 2'b10, 1'b1, 4'h0, 1'b1, 1'b0);
      chk("clean_err_count", 32'(err_count), 32'd0);

      // Stuck-at-0 on alu_d[0]; counter saturates at 255
      stuck0 = 1'b1;
      do_op("fault", 4'h1, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1);
      chk("fault_err_count", 32'(err_count), 32'd1);
      for (int i = 1; i < 300; i++)
         do_op("sat", 4'h1, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1);
      chk("sat_err_count", 32'(err_count), 32'd255);
      stuck0 = 1'b0;

      // Backpressure: response held while a new command waits
      @(negedge clk);
      cmd_a = 4'h3; cmd_b = 4'h4; cmd_s = 2'b00; cmd_cin = 1'b0;
      cmd_valid = 1'b1; rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_a = 4'hF; cmd_b = 4'hF;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("bp_latency", 32'(n), 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_hold_rsp", {26'd0, rsp_valid, rsp_d, rsp_cout}, {26'd0, 1'b1, 4'h7, 1'b0});
         chk("bp_hold_alu", {24'd0, alu_a, alu_b}, 32'h34);
         chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_released", {30'd0, rsp_valid, cmd_ready}, 32'b01);
      chk("bp_alu_kept", 32'(alu_a), 32'h3);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("bp_next_accept", {24'd0, alu_a, alu_b}, 32'hFF);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("bp_next_rsp", {26'd0, rsp_d, rsp_cout, rsp_err}, {26'd0, 4'hE, 1'b1, 1'b0});
      chk("bp_err_count_held", 32'(err_count), 32'd255);
      @(posedge clk);
      @(negedge clk);

      // Reset one cycle after accept aborts the operation
      cmd_a = 4'h7; cmd_b = 4'h9; cmd_s = 2'b00; cmd_cin = 1'b1; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_alu", {19'd0, alu_a, alu_b, alu_s, alu_cin}, 32'd0);
      chk("abort_hs", {30'd0, rsp_valid, cmd_ready}, 32'd0);
      chk("abort_err_count", 32'(err_count), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("abort_no_rsp", 32'(seen), 32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential command front-end for the registered 4-bit ALU stages (ripple-carry or carry-lookahead, with input and output registers). It accepts one operation at a time over a valid/ready command port and drives the ALU operand/select/carry inputs. After the ALU's pipeline latency it samples the registered result, checks it against an internal golden model, and returns it over a valid/ready response port. It is the initiator and checker for the ALU responder, and replaces the free-running stimulus counter in system-level benches and on-chip self-test.

## Interface
- LAT, 2: number of ALU clock edges from operands applied to result registered. 2 for both existing registered stages. Legal range 1–7.
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_a, cmd_b  input  4 each  operands
- cmd_s  input  2  operation select
- cmd_cin  input  1  carry-in
- alu_a, alu_b  output  4 each  operands to ALU
- alu_s  output  2  select to ALU
- alu_cin  output  1  carry-in to ALU
- alu_d  input  4  registered ALU result
- alu_cout  input  1  registered ALU carry-out
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_d  output  4  captured result
- rsp_cout  output  1  captured carry-out
- rsp_err  output  1  captured result or carry differs from golden model
- err_count  output  8  saturating count of mismatching responses

## Operation
- States are IDLE, WAIT and RESP, plus a 3-bit latency counter.
- **IDLE:** cmd_ready=1. When cmd_valid&cmd_ready is high at an edge:
  - register cmd_* onto alu_*;
  - compute and register the expected {cout,d};
  - load counter with LAT;
  - go to WAIT.
- **WAIT:** cmd_ready=0 and alu_* held stable.
  - Counter decrements each edge.
  - At the edge where counter==0, capture alu_d/alu_cout into rsp_d/rsp_cout.
  - At that edge, set rsp_err=(captured {cout,d} != expected).
  - Increment err_count if rsp_err is set; err_count saturates at 255.
  - Go to RESP.
- **RESP:** rsp_valid=1. rsp_* and alu_* are held until rsp_valid&rsp_ready at an edge, then go to IDLE. rsp_valid=0 from that edge.
- **Golden model:** 5-bit sum {cout,d} = A + M + Cin, where M is selected by S:
  - S=00: M=B (add)
  - S=01: M=~B (subtract when Cin=1)
  - S=10: M=0 (transfer/increment)
  - S=11: M=4'hF (decrement/transfer)
- The model matches the ALU's B-path mux exactly. Carry is compared for all four S values.
- Only one command is outstanding at a time. cmd_* are ignored outside IDLE.
- alu_* keep the last command's values in IDLE. They change only at an accept edge.

## Timing
- **Reset (reset=0, asynchronous):**
  - state=IDLE, counter=0;
  - alu_a=alu_b=0, alu_s=0, alu_cin=0;
  - rsp_valid=0, rsp_d=0, rsp_cout=0, rsp_err=0, err_count=0.
- cmd_ready is a registered output with reset value 0. It goes to 1 at the first rising edge after reset deasserts.
- **Latency:** with acceptance at edge E0, capture occurs at edge E(LAT+1). rsp_valid is high from E(LAT+1).
  - With LAT=2, the ALU input register loads at E1 and the output register at E2; sampling at E3 sees the settled value.
- **Throughput:** cmd_ready returns 1 the cycle after the response handshake. The minimum accept-to-accept interval is LAT+3 cycles.
- A response with rsp_ready held high is consumed at the first RESP edge.
- Reset asserted mid-WAIT or mid-RESP aborts the operation immediately. No response is produced and err_count clears.
- err_count at 255 with a further mismatch stays at 255; rsp_err is still set.

## Test plan
- **Reset:** hold reset=0 for 3 cycles, then release. During reset all outputs are 0. cmd_ready=1 one edge after release; rsp_valid stays 0.
- **Add:** bench drives a behavioral ALU with LAT=2 using A=7, B=9, S=00, Cin=1. Required: rsp_d=1, rsp_cout=1, rsp_err=0, rsp_valid exactly 3 edges after accept.
- **Subtract and decrement:** on the same behavioral ALU:
  - S=01, A=5, B=3, Cin=1 gives rsp_d=2, rsp_cout=1.
  - S=11, A=0, Cin=0 gives rsp_d=F, rsp_cout=0.
  - S=10, A=F, Cin=1 gives rsp_d=0, rsp_cout=1.
  - rsp_err=0 in all cases.
- **Fault and saturation:** connect the ALU model with alu_d[0] stuck at 0 and issue A=1, B=0, S=00, Cin=0.
  - Required: rsp_d=0, rsp_err=1, err_count=1.
  - After 300 such commands err_count=255.
- **Backpressure:** hold rsp_ready=0 for 5 cycles while cmd_valid=1 with new operands. rsp_* and alu_* must be stable and cmd_ready=0. On rsp_ready=1, the handshake occurs and cmd_ready=1 the next cycle.
- **Reset mid-operation:** assert reset one cycle after accept. All outputs go to 0 immediately, and no rsp_valid follows after release.
